// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_run_ctrl_pkg                                                 |
// | Brief   : State encodings and helpers shared by the run controller and the |
// |           display select logic.                                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_run_ctrl_pkg;

    typedef logic [1:0] rc_state_t;

    localparam rc_state_t RC_IDLE = 2'b00;
    localparam rc_state_t RC_STEP = 2'b01;
    localparam rc_state_t RC_RUN  = 2'b10;
    localparam rc_state_t RC_HALT = 2'b11;

    // True when an accepted press actually moves the controller out of IDLE.
    function automatic logic rc_leaves_idle(input rc_state_t st, input logic press,
                                            input logic halt);
        return (st == RC_IDLE) && press && !halt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : btn_debounce                                                     |
// | Brief   : Two-flop synchroniser, stable-level debouncer and rising press   |
// |           pulse for a raw push button.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module btn_debounce
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_d;
    logic            press_q;
    logic            press_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // The press pulse is registered together with the level flip, so it is
    // visible in the first cycle the debounced level reads high.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_run_ctrl                                                     |
// | Brief   : CPU execution controller: single-step / continuous clock-enable, |
// |           halt and optional PC breakpoint (RUN_CTRL_BREAKPOINT_EN).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16,
    parameter int PC_W            = 8,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             run_mode_i,
    input  logic             halt_req_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic             bp_valid_i,
    output logic             cpu_step_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic             bp_hit_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    rc_state_t        state_q;
    rc_state_t        state_d;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_press;
    logic             w_bp_stop;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_btn_debounce (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (start_i),
        .press_o (w_press)
    );

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic first_run_q;
    logic bp_hit_q;
    logic bp_hit_d;

    // first_run masks the compare so a resume can step off the breakpoint PC.
    assign w_bp_stop = bp_valid_i && (pc_i == bp_addr_i) && !first_run_q;

    always_comb begin
        bp_hit_d = bp_hit_q;
        if ((state_q == RC_RUN) && !halt_req_i && w_bp_stop) begin
            bp_hit_d = 1'b1;
        end else if (rc_leaves_idle(state_q, w_press, halt_req_i)) begin
            bp_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            first_run_q <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            first_run_q <= (state_d == RC_RUN) && (state_q != RC_RUN);
            bp_hit_q    <= bp_hit_d;
        end
    end

    assign bp_hit_o = bp_hit_q;
`else
    logic w_unused_bp;

    assign w_unused_bp = ^{pc_i, bp_addr_i, bp_valid_i};
    assign w_bp_stop   = 1'b0;
    assign bp_hit_o    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= RC_IDLE;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == RC_HALT);
            cnt_q    <= cnt_d;
        end
    end

    // halt_req outranks the breakpoint, which outranks a press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RC_IDLE: begin
                if (halt_req_i) begin
                    state_d = RC_HALT;
                end else if (w_press) begin
                    state_d = run_mode_i ? RC_RUN : RC_STEP;
                end
            end
            RC_STEP: begin
                state_d = halt_req_i ? RC_HALT : RC_IDLE;
            end
            RC_RUN: begin
                if (halt_req_i) begin
                    state_d = RC_HALT;
                end else if (w_bp_stop || w_press) begin
                    state_d = RC_IDLE;
                end
            end
            default: begin
                state_d = RC_HALT;
            end
        endcase
    end

    always_comb begin
        cpu_step_o = (state_q == RC_STEP) ||
                     ((state_q == RC_RUN) && !halt_req_i && !w_bp_stop);
        cnt_d      = (cpu_step_o && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    assign state_o     = state_q;
    assign halted_o    = halted_q;
    assign cycle_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cpu_run_ctrl                                                  |
// | Brief   : Table-driven, directed and random bench for cpu_run_ctrl with a  |
// |           behavioural reference model.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cpu_run_ctrl;

    localparam int DBC     = 4;
    localparam int CNT_MAX = 15;
    localparam int S_IDLE  = 0;
    localparam int S_STEP  = 1;
    localparam int S_RUN   = 2;
    localparam int S_HALT  = 3;
`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       run_mode;
    logic       halt_req;
    logic [7:0] pc;
    logic [7:0] bp_addr;
    logic       bp_valid;
    logic       cpu_step;
    logic [1:0] state;
    logic       halted;
    logic       bp_hit;
    logic [3:0] cycle_cnt;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES (DBC),
        .DB_W            (4),
        .PC_W            (8),
        .CNT_W           (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .run_mode_i  (run_mode),
        .halt_req_i  (halt_req),
        .pc_i        (pc),
        .bp_addr_i   (bp_addr),
        .bp_valid_i  (bp_valid),
        .cpu_step_o  (cpu_step),
        .state_o     (state),
        .halted_o    (halted),
        .bp_hit_o    (bp_hit),
        .cycle_cnt_o (cycle_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: button samples seen after the two-stage delay, a window
    // of the latest DBC of them, and the controller rules as plain variables.
    bit [1:0] m_pipe;
    bit       m_win[$];
    bit       m_level;
    bit       m_press;
    bit       m_first;
    bit       m_bphit;
    int       m_state;
    int       m_cnt;

    function automatic bit m_bpstop();
        return BP_EN && bp_valid && (pc == bp_addr) && !m_first;
    endfunction

    function automatic bit m_step();
        return (m_state == S_STEP) || ((m_state == S_RUN) && !halt_req && !m_bpstop());
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        check("cpu_step",  {31'd0, cpu_step}, m_step());
        check("state",     {30'd0, state},    m_state);
        check("halted",    {31'd0, halted},   (m_state == S_HALT));
        check("bp_hit",    {31'd0, bp_hit},   m_bphit);
        check("cycle_cnt", {28'd0, cycle_cnt}, m_cnt);
    endtask

    task automatic model_edge();
        bit s2;
        bit flip;
        bit p;
        int nxt;
        if (reset) begin
            m_pipe  = '0;
            m_win.delete();
            m_level = 1'b0;
            m_press = 1'b0;
            m_first = 1'b0;
            m_bphit = 1'b0;
            m_state = S_IDLE;
            m_cnt   = 0;
            return;
        end
        if (m_step() && (m_cnt < CNT_MAX)) m_cnt++;
        nxt = m_state;
        case (m_state)
            S_IDLE: begin
                if (halt_req) nxt = S_HALT;
                else if (m_press) begin
                    nxt     = run_mode ? S_RUN : S_STEP;
                    m_bphit = 1'b0;
                end
            end
            S_STEP: nxt = halt_req ? S_HALT : S_IDLE;
            S_RUN: begin
                if (halt_req) nxt = S_HALT;
                else if (m_bpstop()) begin
                    nxt     = S_IDLE;
                    m_bphit = 1'b1;
                end else if (m_press) nxt = S_IDLE;
            end
            default: nxt = S_HALT;
        endcase
        m_first = (nxt == S_RUN) && (m_state != S_RUN);
        m_state = nxt;
        s2        = m_pipe[0];
        m_pipe[0] = m_pipe[1];
        m_pipe[1] = start;
        m_win.push_back(s2);
        if (m_win.size() > DBC) void'(m_win.pop_front());
        p = 1'b0;
        if (m_win.size() == DBC) begin
            flip = 1'b1;
            foreach (m_win[i]) if (m_win[i] == m_level) flip = 1'b0;
            if (flip) begin
                m_level = ~m_level;
                p       = m_level;
            end
        end
        m_press = p;
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 ns later.
    task automatic tick(input bit chk = 1'b1);
        #1;
        if (chk) model_check();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Emulates the CPU: pc advances once per enabled cycle.
    task automatic ramp_tick();
        bit stp;
        #1;
        stp = m_step();
        tick();
        if (stp) pc = pc + 8'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick(1'b0);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit start;
        bit run_mode;
        bit halt;
        int cycles;
        int exp_state;
        bit exp_step;
        int exp_cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; start = 1'b0; run_mode = 1'b0; halt_req = 1'b0;
        pc = 8'h00; bp_addr = 8'h00; bp_valid = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst.state",     {30'd0, state},     S_IDLE);
        check("rst.cpu_step",  {31'd0, cpu_step},  0);
        check("rst.halted",    {31'd0, halted},    0);
        check("rst.bp_hit",    {31'd0, bp_hit},    0);
        check("rst.cycle_cnt", {28'd0, cycle_cnt}, 0);

        for (int i = 0; i < 10; i++) tbl.push_back('{(i % 2) == 0, 1'b0, 1'b0, 2, S_IDLE, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  6, S_IDLE, 1'b0,  0});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  1, S_STEP, 1'b1,  0});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  1, S_IDLE, 1'b0,  1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 10, S_IDLE, 1'b0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  8, S_IDLE, 1'b0,  1});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  6, S_IDLE, 1'b0,  1});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  1, S_RUN,  1'b1,  1});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  6, S_RUN,  1'b1,  7});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  6, S_RUN,  1'b1, 13});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  1, S_IDLE, 1'b0, 14});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  6, S_IDLE, 1'b0, 14});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  6, S_IDLE, 1'b0, 14});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  1, S_RUN,  1'b1, 14});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  3, S_RUN,  1'b1, 15});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  6, S_RUN,  1'b1, 15});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  6, S_RUN,  1'b1, 15});
        tbl.push_back('{1'b1, 1'b1, 1'b1,  1, S_HALT, 1'b0, 15});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  6, S_HALT, 1'b0, 15});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  8, S_HALT, 1'b0, 15});

        foreach (tbl[k]) begin
            start    = tbl[k].start;
            run_mode = tbl[k].run_mode;
            halt_req = tbl[k].halt;
            repeat (tbl[k].cycles) tick();
            check($sformatf("tbl%0d.state", k),     {30'd0, state},     tbl[k].exp_state);
            check($sformatf("tbl%0d.cpu_step", k),  {31'd0, cpu_step},  tbl[k].exp_step);
            check($sformatf("tbl%0d.cycle_cnt", k), {28'd0, cycle_cnt}, tbl[k].exp_cnt);
        end
        halt_req = 1'b0;

        // Reset for one cycle in the middle of a run with the button held.
        do_reset();
        run_mode = 1'b1;
        start    = 1'b1;
        repeat (7) tick();
        check("mid.run_state", {30'd0, state}, S_RUN);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid.rst_state",  {30'd0, state},     S_IDLE);
        check("mid.rst_step",   {31'd0, cpu_step},  0);
        check("mid.rst_halted", {31'd0, halted},    0);
        check("mid.rst_cnt",    {28'd0, cycle_cnt}, 0);
        repeat (6) tick();
        check("mid.pre_press", {30'd0, state}, S_IDLE);
        tick();
        check("mid.repress",   {30'd0, state}, S_RUN);

        // Breakpoint at 8'h10 with pc advancing on every enabled cycle.
        do_reset();
        bp_valid = 1'b1;
        bp_addr  = 8'h10;
        pc       = 8'h00;
        run_mode = 1'b1;
        start    = 1'b1;
        repeat (7) tick();
        repeat (16) ramp_tick();
        check("bp.step_at_10", {31'd0, cpu_step}, BP_EN ? 0 : 1);
        ramp_tick();
        check("bp.state_after", {30'd0, state},  BP_EN ? S_IDLE : S_RUN);
        check("bp.hit",         {31'd0, bp_hit}, BP_EN ? 1 : 0);
        start = 1'b0;
        repeat (6) ramp_tick();
        start = 1'b1;
        repeat (7) ramp_tick();
        check("bp.resume_step",  {31'd0, cpu_step}, BP_EN ? 1 : 0);
        check("bp.resume_clear", {31'd0, bp_hit},   0);
        ramp_tick();
        check("bp.past_10", {30'd0, state}, BP_EN ? S_RUN : S_IDLE);

        // Random traffic against the model.
        do_reset();
        pc = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0)   start    = ~start;
            if ($urandom_range(0, 31) == 0)  run_mode = ~run_mode;
            if ($urandom_range(0, 49) == 0)  bp_valid = ~bp_valid;
            if ($urandom_range(0, 99) == 0)  bp_addr  = 8'($urandom_range(0, 31));
            if ($urandom_range(0, 63) == 0)  pc       = 8'($urandom_range(0, 31));
            halt_req = ($urandom_range(0, 79) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            ramp_tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
